// File: rtl/piradip_capture_pkg.sv
// Shared types for the sample capture sequencer: capture state encoding and
// timestamp width.
package piradip_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        WAIT_TRIG,
        POST,
        DONE
    } capture_state_t;

    localparam int TIMESTAMP_WIDTH = 48;

    // States in which the buffer is enabled and samples are being tracked.
    function automatic logic is_busy(input capture_state_t s);
        return (s == PRETRIG) || (s == WAIT_TRIG) || (s == POST);
    endfunction

endpackage

// File: rtl/piradip_wrap_counter.sv
// Loadable address counter that wraps from end_i back to start_i, mirroring
// the sample buffer's circular write pointer.
module piradip_wrap_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] start_i,
    input  logic [WIDTH-1:0] end_i,
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] value_q;

    assign value_o = value_q;
    assign next_o  = (value_q == end_i) ? start_i : value_q + WIDTH'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_value_i;
        end else if (inc_i) begin
            value_q <= next_o;
        end
    end

endmodule

// File: rtl/piradip_sample_capture_ctrl.sv
// Trigger/capture sequencer for the stream sample buffer. Optional macro
// PIRADIP_CAPTURE_TIMESTAMP_EN adds a 48-bit cycle timestamp of the trigger.
module piradip_sample_capture_ctrl
    import piradip_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       trigger,
    input  logic                       sample_accept,
    input  logic [ADDR_WIDTH-1:0]      cfg_start,
    input  logic [ADDR_WIDTH-1:0]      cfg_end,
    input  logic [CNT_WIDTH-1:0]       cfg_pre,
    input  logic [CNT_WIDTH-1:0]       cfg_post,
    output logic                       stream_update,
    output logic                       stream_active,
    output logic                       stream_one_shot,
    output logic [ADDR_WIDTH-1:0]      stream_start_offset,
    output logic [ADDR_WIDTH-1:0]      stream_end_offset,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_error,
    output logic [ADDR_WIDTH-1:0]      trigger_addr,
    output logic [TIMESTAMP_WIDTH-1:0] trigger_timestamp
);

    capture_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [CNT_WIDTH-1:0]  pre_q, pre_d;
    logic [CNT_WIDTH-1:0]  post_q, post_d;
    logic [CNT_WIDTH-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_WIDTH-1:0]  post_cnt_q, post_cnt_d;
    logic [ADDR_WIDTH-1:0] trigger_addr_q, trigger_addr_d;
    logic                  done_q, done_d;
    logic                  cfg_error_q, cfg_error_d;
    logic                  upd_q, upd_d;
    logic                  act_q, act_d;
    logic                  trig_q;

    logic                  trig_edge;
    logic                  stop_pulse;
    logic                  cfg_valid;
    logic [CNT_WIDTH-1:0]  depth;
    logic [CNT_WIDTH:0]    need;
    logic                  mirror_load;
    logic                  mirror_inc;
    logic [ADDR_WIDTH-1:0] mirror_value;
    logic [ADDR_WIDTH-1:0] mirror_next;

    assign trig_edge = trigger & ~trig_q;
    assign depth     = CNT_WIDTH'(cfg_end) - CNT_WIDTH'(cfg_start) + CNT_WIDTH'(1);
    assign need      = {1'b0, cfg_pre} + {1'b0, cfg_post};
    assign cfg_valid = (cfg_end >= cfg_start) && (need <= {1'b0, depth});
    assign mirror_inc = sample_accept && is_busy(state_q);

    piradip_wrap_counter #(
        .WIDTH(ADDR_WIDTH)
    ) u_mirror (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .load_i       (mirror_load),
        .load_value_i (cfg_start),
        .inc_i        (mirror_inc),
        .start_i      (start_q),
        .end_i        (end_q),
        .value_o      (mirror_value),
        .next_o       (mirror_next)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        start_d        = start_q;
        end_d          = end_q;
        pre_d          = pre_q;
        post_d         = post_q;
        pre_cnt_d      = pre_cnt_q;
        post_cnt_d     = post_cnt_q;
        trigger_addr_d = trigger_addr_q;
        done_d         = done_q;
        cfg_error_d    = cfg_error_q;
        upd_d          = 1'b0;
        act_d          = 1'b0;
        stop_pulse     = 1'b0;
        mirror_load    = 1'b0;

        if (abort && is_busy(state_q)) begin
            state_d = IDLE;
            upd_d   = 1'b1;
        end else if (arm && !abort && (state_q == IDLE || state_q == DONE)) begin
            done_d = 1'b0;
            if (!cfg_valid) begin
                cfg_error_d = 1'b1;
                state_d     = IDLE;
            end else begin
                start_d     = cfg_start;
                end_d       = cfg_end;
                pre_d       = cfg_pre;
                post_d      = cfg_post;
                cfg_error_d = 1'b0;
                mirror_load = 1'b1;
                pre_cnt_d   = '0;
                upd_d       = 1'b1;
                act_d       = 1'b1;
                state_d     = (cfg_pre == '0) ? WAIT_TRIG : PRETRIG;
            end
        end else begin
            unique case (state_q)
                PRETRIG: begin
                    if (sample_accept && pre_cnt_q != pre_q) begin
                        pre_cnt_d = pre_cnt_q + CNT_WIDTH'(1);
                    end
                    if (pre_cnt_d == pre_q) begin
                        state_d = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trig_edge) begin
                        // A sample written in the trigger cycle still counts as pre-trigger.
                        trigger_addr_d = sample_accept ? mirror_next : mirror_value;
                        post_cnt_d     = '0;
                        if (post_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            upd_d   = 1'b1;
                        end else begin
                            state_d = POST;
                        end
                    end
                end
                POST: begin
                    if (sample_accept) begin
                        post_cnt_d = post_cnt_q + CNT_WIDTH'(1);
                        if (post_cnt_q == post_q - CNT_WIDTH'(1)) begin
                            stop_pulse = 1'b1;
                            state_d    = DONE;
                            done_d     = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            start_q        <= '0;
            end_q          <= '0;
            pre_q          <= '0;
            post_q         <= '0;
            pre_cnt_q      <= '0;
            post_cnt_q     <= '0;
            trigger_addr_q <= '0;
            done_q         <= 1'b0;
            cfg_error_q    <= 1'b0;
            upd_q          <= 1'b0;
            act_q          <= 1'b0;
            trig_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            end_q          <= end_d;
            pre_q          <= pre_d;
            post_q         <= post_d;
            pre_cnt_q      <= pre_cnt_d;
            post_cnt_q     <= post_cnt_d;
            trigger_addr_q <= trigger_addr_d;
            done_q         <= done_d;
            cfg_error_q    <= cfg_error_d;
            upd_q          <= upd_d;
            act_q          <= act_d;
            trig_q         <= trigger;
        end
    end

    // The stop pulse is Mealy so the buffer drops tready right after the last post sample.
    assign stream_update       = upd_q | stop_pulse;
    assign stream_active       = act_q & ~stop_pulse;
    assign stream_one_shot     = 1'b0;
    assign stream_start_offset = start_q;
    assign stream_end_offset   = end_q;
    assign busy                = is_busy(state_q);
    assign done                = done_q;
    assign cfg_error           = cfg_error_q;
    assign trigger_addr        = trigger_addr_q;

`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
    logic [TIMESTAMP_WIDTH-1:0] ts_cnt_q;
    logic [TIMESTAMP_WIDTH-1:0] trigger_ts_q;
    logic                       fire;

    assign fire = (state_q == WAIT_TRIG) && trig_edge && !abort;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ts_cnt_q     <= '0;
            trigger_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TIMESTAMP_WIDTH'(1);
            if (fire) begin
                trigger_ts_q <= ts_cnt_q;
            end
        end
    end

    assign trigger_timestamp = trigger_ts_q;
`else
    assign trigger_timestamp = '0;
`endif

endmodule

// File: tb/tb_piradip_sample_capture_ctrl.sv
// Self-checking bench for piradip_sample_capture_ctrl: directed scenarios and
// randomized captures checked against an accept-count model of the capture.
module tb_piradip_sample_capture_ctrl;

    localparam int AW = 12;
    localparam int CW = AW + 1;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trigger = 1'b0;
    logic          sample_accept = 1'b0;
    logic [AW-1:0] cfg_start = '0;
    logic [AW-1:0] cfg_end = '0;
    logic [CW-1:0] cfg_pre = '0;
    logic [CW-1:0] cfg_post = '0;

    logic          stream_update;
    logic          stream_active;
    logic          stream_one_shot;
    logic [AW-1:0] stream_start_offset;
    logic [AW-1:0] stream_end_offset;
    logic          busy;
    logic          done;
    logic          cfg_error;
    logic [AW-1:0] trigger_addr;
    logic [47:0]   trigger_timestamp;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;

    logic          o_upd, o_act, o_one, o_busy, o_done, o_err;
    logic [AW-1:0] o_taddr, o_soff, o_eoff;
    logic [47:0]   o_ts;
    longint        o_cyc;

    piradip_sample_capture_ctrl #(
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .arm                 (arm),
        .abort               (abort),
        .trigger             (trigger),
        .sample_accept       (sample_accept),
        .cfg_start           (cfg_start),
        .cfg_end             (cfg_end),
        .cfg_pre             (cfg_pre),
        .cfg_post            (cfg_post),
        .stream_update       (stream_update),
        .stream_active       (stream_active),
        .stream_one_shot     (stream_one_shot),
        .stream_start_offset (stream_start_offset),
        .stream_end_offset   (stream_end_offset),
        .busy                (busy),
        .done                (done),
        .cfg_error           (cfg_error),
        .trigger_addr        (trigger_addr),
        .trigger_timestamp   (trigger_timestamp)
    );

    always #5 clk_in = ~clk_in;

    // Clock cycles since reset release, the reference for the trigger timestamp.
    always @(posedge clk_in) cyc <= rst_in ? 64'd0 : cyc + 64'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, sample outputs mid-cycle, return just after the edge.
    task automatic step(input logic acc, input logic trg, input logic a, input logic ab);
        sample_accept = acc;
        trigger       = trg;
        arm           = a;
        abort         = ab;
        @(negedge clk_in);
        o_upd   = stream_update;
        o_act   = stream_active;
        o_one   = stream_one_shot;
        o_busy  = busy;
        o_done  = done;
        o_err   = cfg_error;
        o_taddr = trigger_addr;
        o_soff  = stream_start_offset;
        o_eoff  = stream_end_offset;
        o_ts    = trigger_timestamp;
        o_cyc   = cyc;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":upd"}, o_upd, 0);
        check({tag, ":act"}, o_act, 0);
        check({tag, ":busy"}, o_busy, 0);
        check({tag, ":done"}, o_done, 0);
        check({tag, ":err"}, o_err, 0);
        check({tag, ":taddr"}, o_taddr, 0);
        check({tag, ":soff"}, o_soff, 0);
        check({tag, ":eoff"}, o_eoff, 0);
        check({tag, ":ts"}, o_ts, 0);
    endtask

    // One capture. Trigger rises in the cycle carrying accept number edge1/edge2.
    // kill_mode: 0 normal, 1 abort, 2 reset, applied once kill_at post samples are in.
    task automatic run_capture(input string tag, input int s, input int e, input int pre,
                               input int post, input int edge1, input int edge2,
                               input bit dense, input int kill_mode, input int kill_at);
        int     depth, n_acc, post_seen, hold, guard, exp_addr;
        longint exp_ts;
        bit     fired, finished, first, killing, exp_u;
        logic   acc, trg, ab, prev_trg, exp_stop;
        depth = e - s + 1;
        n_acc = 0; post_seen = 0; hold = 0; guard = 0; exp_addr = 0; exp_ts = 0;
        fired = 0; finished = 0; first = 1;
        cfg_start = AW'(s);
        cfg_end   = AW'(e);
        cfg_pre   = CW'(pre);
        cfg_post  = CW'(post);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check({tag, ":no_upd_in_arm_cycle"}, o_upd, 0);
        prev_trg = 1'b0;
        while (!finished && guard < 600) begin
            guard++;
            acc = dense ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            ab = 1'b0;
            killing = (kill_mode != 0) && fired && (post_seen == kill_at);
            if (killing) begin
                acc = 1'b0;
                ab  = (kill_mode == 1);
            end
            trg = 1'b0;
            if (hold > 0) begin
                trg = 1'b1;
                hold--;
            end else if (acc && (n_acc + 1 == edge1 || n_acc + 1 == edge2)) begin
                trg  = 1'b1;
                hold = 1;
            end
            exp_stop = fired && acc && (post_seen + 1 == post);
            exp_u = first || exp_stop;
            if (killing && kill_mode == 2) rst_in = 1'b1;
            step(acc, trg, 1'b0, ab);
            rst_in = 1'b0;
            check({tag, ":upd"}, o_upd, exp_u);
            if (exp_u) check({tag, ":act"}, o_act, first);
            if (first) begin
                check({tag, ":busy_after_arm"}, o_busy, 1);
                check({tag, ":err_after_arm"}, o_err, 0);
                check({tag, ":done_after_arm"}, o_done, 0);
                check({tag, ":start_off"}, o_soff, s);
                check({tag, ":end_off"}, o_eoff, e);
                check({tag, ":one_shot"}, o_one, 0);
            end
            first = 0;
            if (!fired && trg && !prev_trg && n_acc >= pre) begin
                fired    = 1;
                exp_addr = s + ((n_acc + int'(acc)) % depth);
                exp_ts   = o_cyc;
            end else if (fired && acc) begin
                post_seen++;
            end
            n_acc += int'(acc);
            prev_trg = trg;
            if (exp_stop || killing) finished = 1;
        end
        check({tag, ":finished"}, finished, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (kill_mode == 0) begin
            check({tag, ":busy_end"}, o_busy, 0);
            check({tag, ":done_end"}, o_done, 1);
            check({tag, ":upd_end"}, o_upd, 0);
            check({tag, ":taddr"}, o_taddr, exp_addr);
`ifdef PIRADIP_CAPTURE_TIMESTAMP_EN
            check({tag, ":ts"}, o_ts, exp_ts);
`else
            check({tag, ":ts"}, o_ts, 0);
`endif
        end else if (kill_mode == 1) begin
            check({tag, ":abort_upd"}, o_upd, 1);
            check({tag, ":abort_act"}, o_act, 0);
            check({tag, ":abort_busy"}, o_busy, 0);
            check({tag, ":abort_done"}, o_done, 0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check({tag, ":abort_single_pulse"}, o_upd, 0);
        end else begin
            check_all_zero({tag, ":after_reset"});
        end
    endtask

    initial begin
        int s, depth, pre, post, decoy, real_edge;

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("reset");
        rst_in = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("reset_released");

        run_capture("t1_basic", 16, 31, 4, 8, 10, 0, 1'b1, 0, 0);
        run_capture("t2_early_edge", 16, 31, 4, 8, 2, 6, 1'b1, 0, 0);
        run_capture("t3_wrap", 16, 31, 4, 8, 20, 0, 1'b1, 0, 0);

        cfg_start = 12'd16; cfg_end = 12'd31; cfg_pre = 13'd10; cfg_post = 13'd8;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_oversize:upd", o_upd, 0);
        check("t4_oversize:err", o_err, 1);
        check("t4_oversize:busy", o_busy, 0);
        run_capture("t4_rearm", 16, 31, 4, 8, 9, 0, 1'b0, 0, 0);

        cfg_start = 12'd31; cfg_end = 12'd16; cfg_pre = 13'd0; cfg_post = 13'd1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_reversed:err", o_err, 1);
        check("t4_reversed:busy", o_busy, 0);

        run_capture("t5_abort", 16, 31, 4, 8, 10, 0, 1'b1, 1, 3);
        run_capture("t5_reset", 16, 31, 4, 8, 10, 0, 1'b1, 2, 3);

        repeat (60) step(1'b0, 1'b0, 1'b0, 1'b0);
        run_capture("t6_timestamp", 16, 31, 0, 8, 3, 0, 1'b1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            s         = int'($urandom_range(0, 3000));
            depth     = int'($urandom_range(8, 40));
            pre       = int'($urandom_range(0, depth / 3));
            post      = int'($urandom_range(1, depth / 3));
            decoy     = (pre >= 2) ? int'($urandom_range(1, pre - 1)) : 0;
            real_edge = pre + int'($urandom_range(2, 6));
            run_capture($sformatf("rand%0d", i), s, s + depth - 1, pre, post,
                        decoy, real_edge, 1'b0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
